// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch prediction unit: branch type encodings and the
// PResult/BResult records that travel between IF and EXE.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        BIsNone = 2'd0,
        BIsImme = 2'd1,
        BIsCall = 2'd2,
        BIsRetn = 2'd3
    } branch_type_e;

    typedef struct packed {
        logic         Valid;
        logic [31:0]  PC;
        logic         IsTaken;
        logic [31:0]  Target;
        branch_type_e Type;
        logic [1:0]   Count;
        logic         Hit;
        logic         RetnSuccess;
    } BResult;

    typedef struct packed {
        logic         Valid;
        logic         Hit;
        logic [1:0]   Count;
        branch_type_e Type;
        logic [31:0]  Target;
    } PResult;

    // Fall-through skips the branch and its delay slot.
    localparam logic [31:0] DELAY_SLOT_STEP = 32'd8;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side bus of the branch predictor: lookup request, pipeline control,
// EXE training record in and prediction record out.
interface branch_predict_unit_if;
    import branch_predict_unit_pkg::*;

    logic [31:0] PREIF_PC;
    logic        PREIF_Req;
    logic        IF_Stall;
    logic        IF_Flush;
    BResult      EXE_BResult;
    PResult      IF_PResult;

    modport master (
        output PREIF_PC, PREIF_Req, IF_Stall, IF_Flush, EXE_BResult,
        input  IF_PResult
    );

    modport slave (
        input  PREIF_PC, PREIF_Req, IF_Stall, IF_Flush, EXE_BResult,
        output IF_PResult
    );

endinterface

// File: rtl/bpu_ras.sv
// Speculative circular return-address stack; a push when full overwrites the
// oldest slot and occupancy saturates at DEPTH.
module bpu_ras #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic        pop,
    output logic [31:0] top,
    output logic        empty
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    logic [31:0]   slots [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW:0]   fill;

    assign ptr_next = ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            fill <= '0;
        end else if (push) begin
            ptr  <= ptr_next;
            fill <= (fill == FULL) ? fill : fill + 1'b1;
        end else if (pop && (fill != '0)) begin
            ptr  <= ptr - 1'b1;
            fill <= fill - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            slots[ptr_next] <= push_addr;
        end
    end

    assign top   = slots[ptr];
    assign empty = (fill == '0);

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB predictor with one-cycle lookup, trained by EXE.
// Define BPU_RAS_EN to add the speculative return-address stack.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int INDEX_W   = 7,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        branch_type_e     btype;
        logic [31:0]      target;
        logic [1:0]       cnt;
    } entry_t;

    logic [ENTRIES-1:0] entry_valid;
    entry_t             entry_mem [ENTRIES];

    BResult             train;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    entry_t             wr_entry;

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               bypass;
    logic               rd_valid;
    entry_t             rd_entry;

    logic               lk_valid_q;
    logic               lk_hit_q;
    logic               first_q;
    logic [31:0]        lk_pc_q;
    entry_t             lk_entry_q;
    PResult             held_q;
    PResult             pres_live;
    PResult             pres_out;
    logic               taken;
    logic [31:0]        ras_top;
    logic               ras_empty;
    logic               unused_bits;

    assign train  = bus.EXE_BResult;
    assign lk_idx = bus.PREIF_PC[INDEX_W+1:2];
    assign lk_tag = bus.PREIF_PC[INDEX_W+TAG_W+1:INDEX_W+2];

    // Hits retrain from EXE's view of the counter; misses allocate only when useful.
    always_comb begin
        wr_idx          = train.PC[INDEX_W+1:2];
        wr_entry.tag    = train.PC[INDEX_W+TAG_W+1:INDEX_W+2];
        wr_entry.btype  = train.Type;
        wr_entry.target = train.Target;
        wr_entry.cnt    = train.Hit ? sat_update(train.Count, train.IsTaken)
                                    : (train.IsTaken ? 2'b10 : 2'b01);
        wr_en = train.Valid && (train.Type != BIsNone)
             && (train.Hit || train.IsTaken || (train.Type != BIsImme));
    end

    always_comb begin
        bypass   = wr_en && (wr_idx == lk_idx);
        rd_valid = bypass || entry_valid[lk_idx];
        rd_entry = bypass ? wr_entry : entry_mem[lk_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_valid <= '0;
        end else if (wr_en) begin
            entry_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_mem[wr_idx] <= wr_entry;
        end
    end

    // A stall freezes whatever was shown, so later RAS movement cannot leak into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_valid_q <= 1'b0;
            lk_hit_q   <= 1'b0;
            first_q    <= 1'b1;
            lk_pc_q    <= '0;
            lk_entry_q <= '0;
            held_q     <= '0;
        end else if (bus.IF_Flush) begin
            lk_valid_q <= 1'b0;
            first_q    <= 1'b1;
        end else if (bus.IF_Stall) begin
            first_q    <= 1'b0;
            held_q     <= pres_out;
        end else begin
            lk_valid_q <= bus.PREIF_Req;
            lk_hit_q   <= rd_valid && (rd_entry.tag == lk_tag);
            lk_pc_q    <= bus.PREIF_PC;
            lk_entry_q <= rd_entry;
            first_q    <= 1'b1;
        end
    end

    always_comb begin
        pres_live = '0;
        taken     = 1'b0;
        if (lk_valid_q) begin
            taken = lk_hit_q && ((lk_entry_q.btype == BIsCall) || (lk_entry_q.btype == BIsRetn)
                              || ((lk_entry_q.btype == BIsImme) && lk_entry_q.cnt[1]));
            pres_live.Valid = 1'b1;
            pres_live.Hit   = lk_hit_q;
            pres_live.Count = lk_hit_q ? lk_entry_q.cnt : 2'b01;
            pres_live.Type  = lk_hit_q ? lk_entry_q.btype : BIsNone;
            if (!taken) begin
                pres_live.Target = lk_pc_q + DELAY_SLOT_STEP;
            end else if ((lk_entry_q.btype == BIsRetn) && !ras_empty) begin
                pres_live.Target = ras_top;
            end else begin
                pres_live.Target = lk_entry_q.target;
            end
        end
    end

    assign pres_out       = first_q ? pres_live : held_q;
    assign bus.IF_PResult = pres_out;

`ifdef BPU_RAS_EN
    logic ras_fire;
    logic ras_push;
    logic ras_pop;

    assign ras_fire = first_q && pres_live.Valid && !bus.IF_Flush;
    assign ras_push = ras_fire && (pres_live.Type == BIsCall);
    assign ras_pop  = ras_fire && (pres_live.Type == BIsRetn) && !ras_empty;

    bpu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .push_addr(lk_pc_q + DELAY_SLOT_STEP),
        .pop      (ras_pop),
        .top      (ras_top),
        .empty    (ras_empty)
    );
`else
    logic unused_cfg;

    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_cfg = RAS_DEPTH[0];
`endif

    assign unused_bits = ^{train.RetnSuccess, train.PC, bus.PREIF_PC};

endmodule
